// File: rtl/calc_sequencer.sv
// Operand/opcode sequencer: collects A, B and opcode from a shared entry bus,
// drives the ALU, captures its result/flags and offers them on valid/ready.
// Optional accumulator chaining is enabled by defining CALC_CHAIN_EN.
module calc_sequencer #(
  parameter logic [3:0] OP_MAX = 4'hB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       enter,
  input  logic       clear,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flag,
  output logic [7:0] result,
  output logic [3:0] flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] a_r, a_s, b_r, b_s, res_r, res_s;
  logic [3:0] sel_r, sel_s, flag_r, flag_s;
  logic       valid_r, valid_s, err_r, err_s;
  logic [3:0] op_s;
  logic       reject_s;

  assign op_s     = data_in[3:0];
  // Division by zero is caught here since the ALU cannot report it.
  assign reject_s = (op_s > OP_MAX) || ((op_s == 4'h3) && (b_r == 8'h00));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_A;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath decode; clear overrides any entry.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    sel_s   = sel_r;
    res_s   = res_r;
    flag_s  = flag_r;
    valid_s = valid_r;
    err_s   = 1'b0;
    if (clear) begin
      state_s = WAIT_A;
      valid_s = 1'b0;
    end else begin
      case (state_r)
        WAIT_A: begin
          if (enter) begin
            a_s     = data_in;
            state_s = WAIT_B;
          end else begin
            state_s = WAIT_A;
          end
        end
        WAIT_B: begin
          if (enter) begin
            b_s     = data_in;
            state_s = WAIT_OP;
          end else begin
            state_s = WAIT_B;
          end
        end
        WAIT_OP: begin
          if (enter && reject_s) begin
            err_s   = 1'b1;
            state_s = WAIT_OP;
          end else if (enter) begin
            sel_s   = op_s;
            state_s = EXEC;
          end else begin
            state_s = WAIT_OP;
          end
        end
        EXEC: begin
          res_s   = alu_out;
          flag_s  = alu_flag;
          valid_s = 1'b1;
          state_s = HOLD;
        end
        HOLD: begin
          if (valid_r && res_ready) begin
            valid_s = 1'b0;
`ifdef CALC_CHAIN_EN
            a_s     = res_r;
            state_s = WAIT_B;
`else
            state_s = WAIT_A;
`endif
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = WAIT_A;
        end
      endcase
    end
  end

  // Operand, opcode, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      sel_r   <= 4'h0;
      res_r   <= 8'h00;
      flag_r  <= 4'h0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      a_r     <= a_s;
      b_r     <= b_s;
      sel_r   <= sel_s;
      res_r   <= res_s;
      flag_r  <= flag_s;
      valid_r <= valid_s;
      err_r   <= err_s;
    end
  end

  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_sel   = sel_r;
  assign result    = res_r;
  assign flag      = flag_r;
  assign res_valid = valid_r;
  assign err       = err_r;
  assign state     = state_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus randomized
// operations checked against a transaction-level model; chaining under CALC_CHAIN_EN.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, enter, clear, res_ready;
  logic [7:0] data_in;
  logic [7:0] alu_a, alu_b, alu_out, result;
  logic [3:0] alu_sel, alu_flag, flag;
  logic       res_valid, err;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] S_WAIT_A  = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  // Expected architectural contents, updated per transaction.
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_sel, m_flag;
  bit         m_at_b;

  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enter(enter), .clear(clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_flag(alu_flag), .result(result), .flag(flag), .res_valid(res_valid),
    .res_ready(res_ready), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {flags, result}; add leaves the zero flag clear.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic [3:0]  f;
    case (op)
      4'h0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        f = {1'b0, (a[7] == b[7]) && (r[7] != a[7]), s[8], 1'b0};
      end
      4'h1: begin
        r = a - b;
        f = {a < b, 2'b00, r == 8'h00};
      end
      4'h2: begin
        p = {8'h00, a} * {8'h00, b};
        r = p[7:0];
        f = {2'b00, p[15:8] != 8'h00, r == 8'h00};
      end
      4'h3: begin
        r = (b == 8'h00) ? 8'h00 : a / b;
        f = {3'b000, r == 8'h00};
      end
      default: begin
        r = a ^ b;
        f = {3'b000, r == 8'h00};
      end
    endcase
    return {f, r};
  endfunction

  always_comb {alu_flag, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    data_in = v;
    enter   = 1'b1;
    step();
    enter   = 1'b0;
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_res = 8'h00;
    m_sel = 4'h0; m_flag = 4'h0; m_at_b = 1'b0;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    res_ready = 1'($urandom_range(0, 1));
    if (!m_at_b) begin
      pulse(a);
      m_a = a;
      tests++;
      if (state !== S_WAIT_B || alu_a !== m_a) begin
        fails++;
        $display("FAIL load_a: state=%0d alu_a=%h, expected state=%0d alu_a=%h", state, alu_a, S_WAIT_B, m_a);
      end
    end
    pulse(b);
    m_b = b;
    m_at_b = 1'b0;
    tests++;
    if (state !== S_WAIT_OP || alu_b !== m_b || alu_a !== m_a) begin
      fails++;
      $display("FAIL load_b: state=%0d a=%h b=%h, expected state=%0d a=%h b=%h", state, alu_a, alu_b, S_WAIT_OP, m_a, m_b);
    end
  endtask

  task automatic send_op(input logic [3:0] op, output bit acc);
    bit rej;
    rej = (op > 4'hB) || ((op == 4'h3) && (m_b == 8'h00));
    res_ready = 1'($urandom_range(0, 1));
    pulse({4'($urandom), op});
    if (rej) begin
      acc = 1'b0;
      tests++;
      if (err !== 1'b1 || state !== S_WAIT_OP || alu_sel !== m_sel) begin
        fails++;
        $display("FAIL reject op=%h: err=%b state=%0d sel=%h, expected err=1 state=%0d sel=%h", op, err, state, alu_sel, S_WAIT_OP, m_sel);
      end
      step();
      tests++;
      if (err !== 1'b0 || state !== S_WAIT_OP) begin
        fails++;
        $display("FAIL err_pulse_width: err=%b state=%0d, expected err=0 state=%0d", err, state, S_WAIT_OP);
      end
    end else begin
      acc = 1'b1;
      m_sel = op;
      tests++;
      if (state !== S_EXEC || alu_sel !== m_sel || res_valid !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL accept op=%h: state=%0d sel=%h valid=%b err=%b, expected state=%0d sel=%h valid=0 err=0", op, state, alu_sel, res_valid, err, S_EXEC, m_sel);
      end
    end
  endtask

  task automatic finish_op(input int hold);
    step();
    {m_flag, m_res} = alu_fn(m_a, m_b, m_sel);
    tests++;
    if (state !== S_HOLD || res_valid !== 1'b1 || result !== m_res || flag !== m_flag) begin
      fails++;
      $display("FAIL capture: state=%0d valid=%b result=%h flag=%b, expected state=%0d valid=1 result=%h flag=%b", state, res_valid, result, flag, S_HOLD, m_res, m_flag);
    end
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      data_in = 8'h55;
      enter   = 1'b1;
      step();
      enter   = 1'b0;
      tests++;
      if (state !== S_HOLD || res_valid !== 1'b1 || result !== m_res || flag !== m_flag || alu_a !== m_a) begin
        fails++;
        $display("FAIL backpressure cycle %0d: state=%0d valid=%b result=%h flag=%b a=%h, expected state=%0d valid=1 result=%h flag=%b a=%h", i, state, res_valid, result, flag, alu_a, S_HOLD, m_res, m_flag, m_a);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
`ifdef CALC_CHAIN_EN
    m_a = m_res;
    m_at_b = 1'b1;
`else
    m_at_b = 1'b0;
`endif
    tests++;
    if (res_valid !== 1'b0 || state !== (m_at_b ? S_WAIT_B : S_WAIT_A) || alu_a !== m_a || result !== m_res) begin
      fails++;
      $display("FAIL handshake: valid=%b state=%0d a=%h result=%h, expected valid=0 state=%0d a=%h result=%h", res_valid, state, alu_a, result, (m_at_b ? S_WAIT_B : S_WAIT_A), m_a, m_res);
    end
  endtask

  task automatic do_clear();
    clear   = 1'b1;
    data_in = 8'($urandom);
    enter   = 1'($urandom_range(0, 1));
    step();
    clear   = 1'b0;
    enter   = 1'b0;
    m_at_b  = 1'b0;
    tests++;
    if (state !== S_WAIT_A || res_valid !== 1'b0 || err !== 1'b0 || alu_a !== m_a || alu_b !== m_b ||
        alu_sel !== m_sel || result !== m_res || flag !== m_flag) begin
      fails++;
      $display("FAIL clear: state=%0d valid=%b err=%b a=%h b=%h sel=%h res=%h flag=%b, expected state=0 valid=0 err=0 a=%h b=%h sel=%h res=%h flag=%b",
               state, res_valid, err, alu_a, alu_b, alu_sel, result, flag, m_a, m_b, m_sel, m_res, m_flag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enter = 1'b0; clear = 1'b0; res_ready = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) step();
    tests++;
    if ({state, alu_a, alu_b, alu_sel, result, flag, res_valid, err} !== 37'd0) begin
      fails++;
      $display("FAIL reset_values: got %h, expected 0", {state, alu_a, alu_b, alu_sel, result, flag, res_valid, err});
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (state !== S_WAIT_A || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: state=%0d valid=%b, expected state=0 valid=0", state, res_valid);
    end
  endtask

  task automatic test_add_carry();
    bit acc;
    do_clear();
    load_ab(8'h0F, 8'hF1);
    send_op(4'h0, acc);
    finish_op(0);
    tests++;
    if (result !== 8'h00 || flag !== 4'b0010) begin
      fails++;
      $display("FAIL add_carry: result=%h flag=%b, expected result=00 flag=0010", result, flag);
    end
  endtask

  task automatic test_sub_underflow();
    bit acc;
    do_clear();
    load_ab(8'h05, 8'h07);
    send_op(4'h1, acc);
    finish_op(1);
    tests++;
    if (result !== 8'hFE || flag !== 4'b1000) begin
      fails++;
      $display("FAIL sub_underflow: result=%h flag=%b, expected result=fe flag=1000", result, flag);
    end
  endtask

  task automatic test_reject();
    bit acc;
    do_clear();
    load_ab(8'h08, 8'h00);
    send_op(4'h3, acc);
    send_op(4'h2, acc);
    finish_op(0);
    tests++;
    if (result !== 8'h00 || flag !== 4'b0001) begin
      fails++;
      $display("FAIL reject_recovery: result=%h flag=%b, expected result=00 flag=0001", result, flag);
    end
    do_clear();
    load_ab(8'($urandom), 8'($urandom));
    send_op(4'hC, acc);
    do_clear();
  endtask

  task automatic test_backpressure();
    bit acc;
    do_clear();
    load_ab(8'($urandom), 8'($urandom));
    send_op(4'h0, acc);
    finish_op(5);
  endtask

  task automatic test_abort();
    bit acc;
    do_clear();
    pulse(8'h11);
    m_a = 8'h11;
    clear = 1'b1; enter = 1'b1; data_in = 8'h55;
    step();
    clear = 1'b0; enter = 1'b0;
    tests++;
    if (state !== S_WAIT_A || alu_b !== m_b || alu_a !== m_a) begin
      fails++;
      $display("FAIL clear_enter_wait_b: state=%0d a=%h b=%h, expected state=0 a=%h b=%h", state, alu_a, alu_b, m_a, m_b);
    end
    load_ab(8'($urandom), 8'($urandom));
    send_op(4'h1, acc);
    step();
    {m_flag, m_res} = alu_fn(m_a, m_b, m_sel);
    do_clear();
    load_ab(8'($urandom), 8'($urandom));
    send_op(4'h2, acc);
    step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({state, alu_a, alu_b, alu_sel, result, flag, res_valid, err} !== 37'd0) begin
      fails++;
      $display("FAIL async_reset_in_hold: got %h, expected 0", {state, alu_a, alu_b, alu_sel, result, flag, res_valid, err});
    end
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

`ifdef CALC_CHAIN_EN
  task automatic test_chain();
    bit acc;
    do_clear();
    load_ab(8'h03, 8'h04);
    send_op(4'h2, acc);
    finish_op(0);
    tests++;
    if (result !== 8'h0C) begin
      fails++;
      $display("FAIL chain_first: result=%h, expected 0c", result);
    end
    load_ab(8'hAA, 8'h02);
    send_op(4'h0, acc);
    finish_op(0);
    tests++;
    if (result !== 8'h0E) begin
      fails++;
      $display("FAIL chain_second: result=%h, expected 0e", result);
    end
  endtask
`endif

  task automatic test_random();
    bit acc;
    logic [7:0] b;
    for (int n = 0; n < 40; n++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      load_ab(8'($urandom), b);
      send_op(4'($urandom_range(0, 15)), acc);
      if (acc) begin
        finish_op($urandom_range(0, 3));
      end else begin
        do_clear();
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_underflow();
    test_reject();
    test_backpressure();
    test_abort();
`ifdef CALC_CHAIN_EN
    test_chain();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
